// File: rtl/seven_seg_pkg.sv
// ---------------------------------------------------------------------------
// seven_seg_pkg
//   Shared constants for the seven-segment display controller:
//   display mode codes, active-low glyphs (bit0 = segment a) and the FSM
//   state encoding.
// ---------------------------------------------------------------------------
package seven_seg_pkg;

    // Display mode codes, sampled together with a load request.
    localparam logic [1:0] MODE_STATIC = 2'b00;
    localparam logic [1:0] MODE_BLINK  = 2'b01;
    localparam logic [1:0] MODE_REVEAL = 2'b10;
    localparam logic [1:0] MODE_BLANK  = 2'b11;

    // Active-low glyphs: a segment is lit when its bit is 0.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_DIGIT [10] = '{
        7'b1000000,   // 0
        7'b1111001,   // 1
        7'b0100100,   // 2
        7'b0110000,   // 3
        7'b0011001,   // 4
        7'b0010010,   // 5
        7'b0000010,   // 6
        7'b1111000,   // 7
        7'b0000000,   // 8
        7'b0010000    // 9
    };

    // Controller FSM states.
    typedef enum logic {
        S_SHOW   = 1'b0,
        S_REVEAL = 1'b1
    } state_e;

endpackage : seven_seg_pkg

// File: rtl/seven_seg_decode.sv
// ---------------------------------------------------------------------------
// seven_seg_decode
//   Purely combinational digit-to-glyph decoder.
//   Values 0..9 map to the usual numerals, 10..15 map to a dash. Narrow
//   values are zero-extended to 4 bits before decoding.
//
// Ports
//   value_i  in   DIGIT_W  digit value
//   seg_o    out  7        active-low segments, bit0 = seg a
// ---------------------------------------------------------------------------
module seven_seg_decode
    import seven_seg_pkg::*;
#(
    parameter int DIGIT_W = 3
) (
    input  logic [DIGIT_W-1:0] value_i,
    output logic [6:0]         seg_o
);

    logic [3:0] value_ext;

    assign value_ext = 4'(value_i);

    always_comb begin
        seg_o = SEG_DASH;
        if (value_ext < 4'd10) begin
            seg_o = SEG_DIGIT[value_ext];
        end
    end

endmodule : seven_seg_decode

// File: rtl/seven_segment_ctrl.sv
// ---------------------------------------------------------------------------
// seven_segment_ctrl
//   Registered N-digit seven-segment display controller. New content
//   (digits, blink mask, mode) is latched on an accepted load; each digit is
//   decoded to an active-low glyph, masked according to the display mode and
//   registered before leaving the block, so the display follows a load after
//   two clock edges.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_SHOW   | idle/display; ready=1; STATIC, BLINK or BLANK rendering
//   S_REVEAL | timed reveal, HEX0 first; ready=0; done pulses on exit
//
// Ports
//   clk_i         in   1             system clock
//   reset_i       in   1             asynchronous, active-high reset
//   load_i        in   1             latch new content (only when ready_o=1)
//   ready_o       out  1             load will be accepted this cycle
//   mode_i        in   2             STATIC/BLINK/REVEAL/BLANK, sampled with load
//   digits_i      in   N*DIGIT_W     digit k = digits_i[k*DIGIT_W +: DIGIT_W]
//   blink_mask_i  in   N             1 = digit k blinks in BLINK mode
//   done_o        out  1             one-cycle pulse when a reveal completes
//   hex_o         out  N*7           digit k segments = hex_o[k*7 +: 7]
// ---------------------------------------------------------------------------
module seven_segment_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 3,
    parameter int BLINK_DIV  = 12_500_000,
    parameter int REVEAL_DIV = 25_000_000
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          load_i,
    output logic                          ready_o,
    input  logic [1:0]                    mode_i,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]         blink_mask_i,
    output logic                          done_o,
    output logic [NUM_DIGITS*7-1:0]       hex_o
);

    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam int STEP_W  = $clog2(REVEAL_DIV);
    localparam int IDX_W   = $clog2(NUM_DIGITS + 1);

    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(REVEAL_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    state_e                          state_q;
    logic                            ready_q;
    logic                            done_q;
    logic [IDX_W-1:0]                idx_q;
    logic [STEP_W-1:0]               step_q;
    logic [NUM_DIGITS*DIGIT_W-1:0]   digits_q;
    logic [NUM_DIGITS-1:0]           mask_q;
    logic [1:0]                      mode_q;

    logic [BLINK_W-1:0]              blink_cnt_q;
    logic                            phase_on_q;

    logic [NUM_DIGITS*7-1:0]         hex_q;
    logic [NUM_DIGITS*7-1:0]         hex_d;
    logic [NUM_DIGITS-1:0]           show_d;

    logic [6:0]                      glyph [NUM_DIGITS];
    logic                            load_accept;

    assign load_accept = load_i && ready_q;

    // -----------------------------------------------------------------------
    // Control FSM: content latches, reveal sequencing and handshake outputs.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= S_SHOW;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            idx_q    <= '0;
            step_q   <= '0;
            digits_q <= '0;
            mask_q   <= '0;
            mode_q   <= MODE_BLANK;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_SHOW: begin
                    if (load_accept) begin
                        digits_q <= digits_i;
                        mask_q   <= blink_mask_i;
                        mode_q   <= mode_i;
                        if (mode_i == MODE_REVEAL) begin
                            state_q <= S_REVEAL;
                            ready_q <= 1'b0;
                            idx_q   <= '0;
                            step_q  <= '0;
                        end
                    end
                end
                S_REVEAL: begin
                    if (step_q == STEP_LAST) begin
                        step_q <= '0;
                        idx_q  <= idx_q + 1'b1;
                        // Last digit uncovered: hand back to SHOW with the
                        // full code left on the display.
                        if (idx_q == IDX_LAST) begin
                            state_q <= S_SHOW;
                            ready_q <= 1'b1;
                            done_q  <= 1'b1;
                            mode_q  <= MODE_STATIC;
                        end
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_SHOW;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Free-running blink timer. An accepted load restarts it in the ON phase,
    // taking priority over a wrap in the same cycle.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            blink_cnt_q <= '0;
            phase_on_q  <= 1'b1;
        end else if (load_accept) begin
            blink_cnt_q <= '0;
            phase_on_q  <= 1'b1;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_q <= '0;
            phase_on_q  <= ~phase_on_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Per-digit decode.
    // -----------------------------------------------------------------------
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        seven_seg_decode #(
            .DIGIT_W (DIGIT_W)
        ) u_decode (
            .value_i (digits_q[k*DIGIT_W +: DIGIT_W]),
            .seg_o   (glyph[k])
        );
    end

    // -----------------------------------------------------------------------
    // Display masking. During a reveal, idx_q digits are uncovered starting
    // from HEX0 (rightmost) and moving left.
    // -----------------------------------------------------------------------
    always_comb begin
        show_d = '0;
        hex_d  = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (state_q == S_REVEAL) begin
                show_d[k] = (k < int'(idx_q));
            end else begin
                case (mode_q)
                    MODE_BLANK: show_d[k] = 1'b0;
                    MODE_BLINK: show_d[k] = !(mask_q[k] && !phase_on_q);
                    default:    show_d[k] = 1'b1;
                endcase
            end
            hex_d[k*7 +: 7] = show_d[k] ? glyph[k] : SEG_BLANK;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hex_q <= '1;
        end else begin
            hex_q <= hex_d;
        end
    end

    assign ready_o = ready_q;
    assign done_o  = done_q;
    assign hex_o   = hex_q;

endmodule : seven_segment_ctrl
